// File: rtl/nic_pipe_pkg.sv
// Shared definitions for the NIC control/status pipes: reason codes, FSM states
// and helpers that locate the fields inside a {seq, reason, status} word.
package nic_pipe_pkg;

   localparam logic [1:0] RSN_INIT   = 2'b00;
   localparam logic [1:0] RSN_CHANGE = 2'b01;
   localparam logic [1:0] RSN_HB     = 2'b10;
   localparam logic [1:0] RSN_FORCE  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   function automatic int rsn_lsb(input int status_w);
      return status_w;
   endfunction

   function automatic int seq_lsb(input int status_w);
      return status_w + 2;
   endfunction

   function automatic int data_width(input int seq_w, input int status_w);
      return seq_w + 2 + status_w;
   endfunction

endpackage

// File: rtl/nic_mac_status_pipe_tx.sv
// Transmit side of the MAC status pipe: sends {seq, reason, status} words on init,
// status change, software force and heartbeat, coalescing events while a word is busy.
module nic_mac_status_pipe_tx
   import nic_pipe_pkg::*;
#(
   parameter int STATUS_W         = 8,
   parameter int SEQ_W            = 6,
   parameter int GAP_CYCLES       = 4,
   parameter int HEARTBEAT_CYCLES = 1024
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic [STATUS_W-1:0]                      mac_status,
   input  logic                                     force_report,
   output logic [data_width(SEQ_W, STATUS_W)-1:0]   STATUS_MAC_pipe_data,
   output logic                                     STATUS_MAC_pipe_req,
   input  logic                                     STATUS_MAC_pipe_ack,
   output logic [7:0]                               coalesce_count,
   output logic                                     busy
);

   localparam int RSN_LSB = rsn_lsb(STATUS_W);
   localparam int CNT_MAX = (HEARTBEAT_CYCLES > GAP_CYCLES) ? HEARTBEAT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HB_LAST  = (HEARTBEAT_CYCLES == 0) ? '0 : CNT_W'(HEARTBEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

   state_t               state;
   logic [SEQ_W-1:0]     seq;
   logic [STATUS_W-1:0]  last_sent;
   logic [STATUS_W-1:0]  prev_status;
   logic [CNT_W-1:0]     hb_cnt;
   logic [CNT_W-1:0]     gap_cnt;
   logic                 init_pending;
   logic                 force_pending;
   logic                 hb_pending;
   logic                 hb_hit;
   logic                 any_src;
   logic [1:0]           sel_reason;

   assign hb_hit = (HEARTBEAT_CYCLES != 0) && (hb_cnt == HB_LAST);

   // Highest-priority report source visible this cycle; only consulted in IDLE.
   always_comb begin
      sel_reason = RSN_HB;
      any_src    = init_pending | force_pending | force_report |
                   (mac_status != last_sent) | hb_pending | hb_hit;
      if (init_pending)
         sel_reason = RSN_INIT;
      else if (force_pending || force_report)
         sel_reason = RSN_FORCE;
      else if (mac_status != last_sent)
         sel_reason = RSN_CHANGE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                <= ST_IDLE;
         STATUS_MAC_pipe_req  <= 1'b0;
         STATUS_MAC_pipe_data <= '0;
         busy                 <= 1'b0;
         seq                  <= '0;
         last_sent            <= '0;
         prev_status          <= '0;
         coalesce_count       <= 8'd0;
         hb_cnt               <= '0;
         gap_cnt              <= '0;
         init_pending         <= 1'b1;
         force_pending        <= 1'b0;
         hb_pending           <= 1'b0;
      end else begin
         prev_status <= mac_status;
         if (state != ST_IDLE && mac_status != prev_status && coalesce_count != 8'hFF)
            coalesce_count <= coalesce_count + 8'd1;

         // The heartbeat counter parks at its last value until a transfer restarts it.
         if (HEARTBEAT_CYCLES != 0 && state != ST_SEND) begin
            if (hb_hit)
               hb_pending <= 1'b1;
            else
               hb_cnt <= hb_cnt + CNT_W'(1);
         end

         if (force_report && state != ST_IDLE)
            force_pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (any_src) begin
                  STATUS_MAC_pipe_data <= {seq, sel_reason, mac_status};
                  STATUS_MAC_pipe_req  <= 1'b1;
                  busy                 <= 1'b1;
                  state                <= ST_SEND;
                  if (sel_reason == RSN_INIT)
                     init_pending <= 1'b0;
                  if (sel_reason == RSN_FORCE)
                     force_pending <= 1'b0;
                  else if (force_report)
                     force_pending <= 1'b1;
               end
            end
            ST_SEND: begin
               if (STATUS_MAC_pipe_ack) begin
                  seq                 <= seq + SEQ_W'(1);
                  last_sent           <= STATUS_MAC_pipe_data[RSN_LSB-1:0];
                  STATUS_MAC_pipe_req <= 1'b0;
                  hb_cnt              <= '0;
                  hb_pending          <= 1'b0;
                  gap_cnt             <= '0;
                  if (GAP_CYCLES == 0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nic_mac_status_pipe_tx.sv
// Directed scenarios plus a randomized phase for the MAC status pipe transmitter,
// checked every cycle against a transaction-level model of the reporting rules.
module tb_nic_mac_status_pipe_tx;
   import nic_pipe_pkg::*;

   localparam int STATUS_W = 8;
   localparam int SEQ_W    = 6;
   localparam int GAP      = 4;
   localparam int HB       = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [7:0]  mac_status = 8'h05;
   logic        force_report = 1'b0;
   logic [15:0] STATUS_MAC_pipe_data;
   logic        STATUS_MAC_pipe_req;
   logic        STATUS_MAC_pipe_ack = 1'b1;
   logic [7:0]  coalesce_count;
   logic        busy;

   always #5 clk = ~clk;

   nic_mac_status_pipe_tx #(
      .STATUS_W(STATUS_W), .SEQ_W(SEQ_W), .GAP_CYCLES(GAP), .HEARTBEAT_CYCLES(HB)
   ) dut (
      .clk(clk), .reset_n(reset_n), .mac_status(mac_status), .force_report(force_report),
      .STATUS_MAC_pipe_data(STATUS_MAC_pipe_data), .STATUS_MAC_pipe_req(STATUS_MAC_pipe_req),
      .STATUS_MAC_pipe_ack(STATUS_MAC_pipe_ack), .coalesce_count(coalesce_count), .busy(busy)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a word is either in flight, in its post-transfer gap, or nothing is busy.
   bit          m_inflight, m_init, m_force, m_hb;
   int          m_gap_left, m_seq, m_coal, m_quiet;
   logic [7:0]  m_last, m_prev;
   logic [15:0] m_word;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_inflight = 0; m_init = 1; m_force = 0; m_hb = 0;
      m_gap_left = 0; m_seq = 0; m_coal = 0; m_quiet = 0;
      m_last = 8'h00; m_prev = 8'h00; m_word = 16'h0000;
   endtask

   task automatic model_step();
      bit was_busy, hb_due;
      int rsn;
      was_busy = m_inflight || (m_gap_left > 0);
      if (was_busy && mac_status != m_prev && m_coal < 255) m_coal++;
      m_prev = mac_status;
      hb_due = (HB > 0) && (m_quiet == HB - 1);
      if (!m_inflight && HB > 0) begin
         if (hb_due) m_hb = 1;
         else m_quiet++;
      end
      if (m_inflight) begin
         if (force_report) m_force = 1;
         if (STATUS_MAC_pipe_ack) begin
            m_seq      = (m_seq + 1) % 64;
            m_last     = m_word[7:0];
            m_inflight = 0;
            m_quiet    = 0;
            m_hb       = 0;
            m_gap_left = GAP;
         end
      end else if (m_gap_left > 0) begin
         if (force_report) m_force = 1;
         m_gap_left--;
      end else begin
         rsn = -1;
         if (m_init) rsn = int'(RSN_INIT);
         else if (m_force || force_report) rsn = int'(RSN_FORCE);
         else if (mac_status != m_last) rsn = int'(RSN_CHANGE);
         else if (m_hb || hb_due) rsn = int'(RSN_HB);
         if (rsn >= 0) begin
            m_word     = {6'(m_seq), 2'(rsn), mac_status};
            m_inflight = 1;
            if (rsn == int'(RSN_INIT)) m_init = 0;
            if (rsn == int'(RSN_FORCE)) m_force = 0;
            else if (force_report) m_force = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
      check_output("req",      32'(STATUS_MAC_pipe_req),  32'(m_inflight));
      check_output("data",     32'(STATUS_MAC_pipe_data), 32'(m_word));
      check_output("busy",     32'(busy),                 32'(m_inflight || (m_gap_left > 0)));
      check_output("coalesce", 32'(coalesce_count),       32'(m_coal));
   endtask

   task automatic apply_stimulus(input logic [7:0] st, input logic frc, input logic ak);
      mac_status          = st;
      force_report        = frc;
      STATUS_MAC_pipe_ack = ak;
      tick();
      force_report = 1'b0;
   endtask

   int          req_seen;
   int          hb_words;
   int          exp_seq;
   int          last_rise;
   int          cyc;
   bit          prev_req;
   bit          wrap_seen;
   logic [7:0]  st;

   initial begin
      model_reset();
      #1 reset_n = 1'b0;
      repeat (3) apply_stimulus(8'h05, 1'b0, 1'b1);

      // Reset release: one INIT word, then silence.
      reset_n = 1'b1;
      apply_stimulus(8'h05, 1'b0, 1'b1);
      check_output("t1_init_req",  32'(STATUS_MAC_pipe_req),  32'd1);
      check_output("t1_init_data", 32'(STATUS_MAC_pipe_data), 32'h0005);
      apply_stimulus(8'h05, 1'b0, 1'b1);
      req_seen = 0;
      repeat (8) begin
         apply_stimulus(8'h05, 1'b0, 1'b1);
         if (STATUS_MAC_pipe_req) req_seen++;
      end
      check_output("t1_no_more_req", 32'(req_seen), 32'd0);

      // Status change in IDLE.
      apply_stimulus(8'h0A, 1'b0, 1'b1);
      check_output("t2_change_data", 32'(STATUS_MAC_pipe_data), 32'h050A);
      apply_stimulus(8'h0A, 1'b0, 1'b1);
      repeat (5) apply_stimulus(8'h0A, 1'b0, 1'b1);

      // Consumer stalls while the status keeps moving.
      apply_stimulus(8'h33, 1'b0, 1'b0);
      apply_stimulus(8'h44, 1'b0, 1'b0);
      apply_stimulus(8'h55, 1'b0, 1'b0);
      apply_stimulus(8'h66, 1'b0, 1'b0);
      repeat (6) apply_stimulus(8'h66, 1'b0, 1'b0);
      check_output("t3_req_held",   32'(STATUS_MAC_pipe_req),  32'd1);
      check_output("t3_data_held",  32'(STATUS_MAC_pipe_data), 32'h0933);
      check_output("t3_coalesce",   32'(coalesce_count),       32'd3);
      repeat (6) apply_stimulus(8'h66, 1'b0, 1'b1);
      check_output("t3_final_req",  32'(STATUS_MAC_pipe_req),  32'd1);
      check_output("t3_final_data", 32'(STATUS_MAC_pipe_data), 32'h0D66);
      apply_stimulus(8'h66, 1'b0, 1'b1);

      // Two force pulses during GAP collapse into one FORCE word.
      apply_stimulus(8'h66, 1'b1, 1'b1);
      apply_stimulus(8'h66, 1'b0, 1'b1);
      apply_stimulus(8'h66, 1'b1, 1'b1);
      apply_stimulus(8'h66, 1'b0, 1'b1);
      apply_stimulus(8'h66, 1'b0, 1'b1);
      check_output("t4_force_req",  32'(STATUS_MAC_pipe_req),  32'd1);
      check_output("t4_force_data", 32'(STATUS_MAC_pipe_data), 32'h1366);
      apply_stimulus(8'h66, 1'b0, 1'b1);
      req_seen = 0;
      repeat (8) begin
         apply_stimulus(8'h66, 1'b0, 1'b1);
         if (STATUS_MAC_pipe_req) req_seen++;
      end
      check_output("t4_single_force", 32'(req_seen), 32'd0);

      // Heartbeats with no other activity until the sequence number wraps.
      exp_seq = 5; hb_words = 0; last_rise = -1; cyc = 0; prev_req = 0; wrap_seen = 0;
      for (int i = 0; i < 1100; i++) begin
         apply_stimulus(8'h66, 1'b0, 1'b1);
         cyc++;
         if (STATUS_MAC_pipe_req && !prev_req) begin
            hb_words++;
            check_output("t5_hb_reason", 32'(STATUS_MAC_pipe_data[rsn_lsb(STATUS_W) +: 2]), 32'(RSN_HB));
            check_output("t5_hb_seq",    32'(STATUS_MAC_pipe_data[seq_lsb(STATUS_W) +: SEQ_W]), 32'(exp_seq));
            if (last_rise >= 0)
               check_output("t5_hb_spacing", 32'(cyc - last_rise), 32'(HB + 1));
            if (exp_seq == 0) wrap_seen = 1;
            exp_seq   = (exp_seq + 1) % 64;
            last_rise = cyc;
         end
         prev_req = STATUS_MAC_pipe_req;
      end
      check_output("t5_hb_count", 32'(hb_words >= 60), 32'd1);
      check_output("t5_seq_wrap", 32'(wrap_seen),      32'd1);

      // Randomized status, force and back-pressure.
      for (int i = 0; i < 400; i++) begin
         st = mac_status;
         if ($urandom_range(0, 7) == 0) st = 8'($urandom_range(0, 3)) << 2;
         apply_stimulus(st, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
      end

      // Reset while a word is stalled in flight.
      apply_stimulus(8'hC3, 1'b1, 1'b0);
      for (int i = 0; i < 40 && !m_inflight; i++) apply_stimulus(8'hC3, 1'b0, 1'b0);
      check_output("t6_inflight", 32'(STATUS_MAC_pipe_req), 32'd1);
      reset_n = 1'b0;
      #1;
      check_output("t6_async_req_drop", 32'(STATUS_MAC_pipe_req), 32'd0);
      check_output("t6_async_busy",     32'(busy),                32'd0);
      model_reset();
      repeat (2) apply_stimulus(8'hC3, 1'b0, 1'b1);
      reset_n = 1'b1;
      apply_stimulus(8'hC3, 1'b0, 1'b1);
      check_output("t6_init_req",  32'(STATUS_MAC_pipe_req),  32'd1);
      check_output("t6_init_data", 32'(STATUS_MAC_pipe_data), 32'h00C3);
      repeat (8) apply_stimulus(8'hC3, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
